// File: rtl/rename_pkg.sv
// rename_pkg: shared rename constants, index types and renamed-uop record
package rename_pkg;
  localparam int WIDTH = 4;
  localparam int NUM_AREG = 32;
  localparam int NUM_PREG = 64;
  localparam int AREG_W = $clog2(NUM_AREG);
  localparam int PREG_W = $clog2(NUM_PREG);
  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef struct packed {
    logic  valid;
    logic  wen;
    preg_t pdst;
    preg_t old_pdst;
    preg_t prs1;
    preg_t prs2;
  } uop_t;
endpackage

// File: rtl/rename_bypass.sv
// rename_bypass: youngest older-lane writer match for one lookup, else the RAT value
module rename_bypass
  import rename_pkg::*;
#(
  parameter int LANE = 0
) (
  input  logic [WIDTH-1:0] wen,
  input  areg_t            rd   [WIDTH],
  input  preg_t            pidx [WIDTH],
  input  areg_t            key,
  input  preg_t            base,
  output preg_t            res
);
  always_comb begin
    res = base;
    for (int j = 0; j < WIDTH; j++) if (j < LANE && wen[j] && rd[j] == key) res = pidx[j];
  end
endmodule

// File: rtl/rename_map.sv
// rename_map: 4-wide register rename with speculative/committed RATs and one-entry output register
module rename_map
  import rename_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic io_in_valid_0, io_in_valid_1, io_in_valid_2, io_in_valid_3,
  input  logic io_in_wen_0, io_in_wen_1, io_in_wen_2, io_in_wen_3,
  input  logic [4:0] io_in_rd_0, io_in_rd_1, io_in_rd_2, io_in_rd_3,
  input  logic [4:0] io_in_rs1_0, io_in_rs1_1, io_in_rs1_2, io_in_rs1_3,
  input  logic [4:0] io_in_rs2_0, io_in_rs2_1, io_in_rs2_2, io_in_rs2_3,
  output logic io_in_ready,
  output logic io_fl_req_0, io_fl_req_1, io_fl_req_2, io_fl_req_3,
  input  logic [5:0] io_fl_pidx_0, io_fl_pidx_1, io_fl_pidx_2, io_fl_pidx_3,
  input  logic io_fl_pvld_0, io_fl_pvld_1, io_fl_pvld_2, io_fl_pvld_3,
  input  logic io_fl_busy,
  output logic io_out_valid_0, io_out_valid_1, io_out_valid_2, io_out_valid_3,
  input  logic io_out_ready,
  output logic io_out_wen_0, io_out_wen_1, io_out_wen_2, io_out_wen_3,
  output logic [5:0] io_out_pdst_0, io_out_pdst_1, io_out_pdst_2, io_out_pdst_3,
  output logic [5:0] io_out_old_pdst_0, io_out_old_pdst_1, io_out_old_pdst_2, io_out_old_pdst_3,
  output logic [5:0] io_out_prs1_0, io_out_prs1_1, io_out_prs1_2, io_out_prs1_3,
  output logic [5:0] io_out_prs2_0, io_out_prs2_1, io_out_prs2_2, io_out_prs2_3,
  input  logic io_cmt_valid_0, io_cmt_valid_1, io_cmt_valid_2, io_cmt_valid_3,
  input  logic [4:0] io_cmt_rd_0, io_cmt_rd_1, io_cmt_rd_2, io_cmt_rd_3,
  input  logic [5:0] io_cmt_pdst_0, io_cmt_pdst_1, io_cmt_pdst_2, io_cmt_pdst_3,
  input  logic io_flush
);
  logic [WIDTH-1:0] in_valid, in_wen, fl_pvld, fl_req, cmt_valid, wen;
  areg_t in_rd [WIDTH], in_rs1 [WIDTH], in_rs2 [WIDTH], cmt_rd [WIDTH];
  preg_t fl_pidx [WIDTH], cmt_pdst [WIDTH];
  preg_t spec_rat [NUM_AREG], arch_rat [NUM_AREG], arch_nxt [NUM_AREG];
  uop_t nxt [WIDTH], out_q [WIDTH];
  logic any_out, in_ready;
  assign in_valid = {io_in_valid_3, io_in_valid_2, io_in_valid_1, io_in_valid_0};
  assign in_wen = {io_in_wen_3, io_in_wen_2, io_in_wen_1, io_in_wen_0};
  assign fl_pvld = {io_fl_pvld_3, io_fl_pvld_2, io_fl_pvld_1, io_fl_pvld_0};
  assign cmt_valid = {io_cmt_valid_3, io_cmt_valid_2, io_cmt_valid_1, io_cmt_valid_0};
  assign in_rd = '{io_in_rd_0, io_in_rd_1, io_in_rd_2, io_in_rd_3};
  assign in_rs1 = '{io_in_rs1_0, io_in_rs1_1, io_in_rs1_2, io_in_rs1_3};
  assign in_rs2 = '{io_in_rs2_0, io_in_rs2_1, io_in_rs2_2, io_in_rs2_3};
  assign cmt_rd = '{io_cmt_rd_0, io_cmt_rd_1, io_cmt_rd_2, io_cmt_rd_3};
  assign fl_pidx = '{io_fl_pidx_0, io_fl_pidx_1, io_fl_pidx_2, io_fl_pidx_3};
  assign cmt_pdst = '{io_cmt_pdst_0, io_cmt_pdst_1, io_cmt_pdst_2, io_cmt_pdst_3};
  assign any_out = out_q[0].valid | out_q[1].valid | out_q[2].valid | out_q[3].valid;
  assign in_ready = !io_fl_busy && !io_flush && (!any_out || io_out_ready);
  assign io_in_ready = in_ready;
  assign fl_req = wen & {WIDTH{in_ready}};
  assign {io_fl_req_3, io_fl_req_2, io_fl_req_1, io_fl_req_0} = fl_req;
  for (genvar k = 0; k < WIDTH; k++) begin : g_lane
    preg_t p1, p2, po;
    assign wen[k] = in_valid[k] & in_wen[k] & (in_rd[k] != '0);
    rename_bypass #(.LANE(k)) u_rs1 (.wen(wen), .rd(in_rd), .pidx(fl_pidx), .key(in_rs1[k]), .base(spec_rat[in_rs1[k]]), .res(p1));
    rename_bypass #(.LANE(k)) u_rs2 (.wen(wen), .rd(in_rd), .pidx(fl_pidx), .key(in_rs2[k]), .base(spec_rat[in_rs2[k]]), .res(p2));
    rename_bypass #(.LANE(k)) u_rd (.wen(wen), .rd(in_rd), .pidx(fl_pidx), .key(in_rd[k]), .base(spec_rat[in_rd[k]]), .res(po));
    assign nxt[k] = '{valid: in_valid[k], wen: wen[k], pdst: wen[k] ? fl_pidx[k] : '0, old_pdst: po, prs1: p1, prs2: p2};
  end
  always_comb begin
    arch_nxt = arch_rat;
    for (int k = 0; k < WIDTH; k++) if (cmt_valid[k] && cmt_rd[k] != '0) arch_nxt[cmt_rd[k]] = cmt_pdst[k];
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_AREG; i++) begin
        spec_rat[i] <= PREG_W'(i);
        arch_rat[i] <= PREG_W'(i);
      end
    end else begin
      arch_rat <= arch_nxt;
      if (io_flush) spec_rat <= arch_nxt;
      else if (in_ready) for (int k = 0; k < WIDTH; k++) if (wen[k]) spec_rat[in_rd[k]] <= fl_pidx[k];
    end
  end
  always_ff @(posedge clock) begin
    if (reset) out_q <= '{default: '0};
    else if (io_flush) for (int k = 0; k < WIDTH; k++) out_q[k].valid <= 1'b0;
    else if (in_ready) out_q <= nxt;
    else if (io_out_ready) for (int k = 0; k < WIDTH; k++) out_q[k].valid <= 1'b0;
  end
  always_ff @(posedge clock) if (!reset) assert (fl_pvld == fl_req);
  assign {io_out_valid_3, io_out_valid_2, io_out_valid_1, io_out_valid_0} = {out_q[3].valid, out_q[2].valid, out_q[1].valid, out_q[0].valid};
  assign {io_out_wen_3, io_out_wen_2, io_out_wen_1, io_out_wen_0} = {out_q[3].wen, out_q[2].wen, out_q[1].wen, out_q[0].wen};
  assign {io_out_pdst_3, io_out_pdst_2, io_out_pdst_1, io_out_pdst_0} = {out_q[3].pdst, out_q[2].pdst, out_q[1].pdst, out_q[0].pdst};
  assign {io_out_old_pdst_3, io_out_old_pdst_2, io_out_old_pdst_1, io_out_old_pdst_0} = {out_q[3].old_pdst, out_q[2].old_pdst, out_q[1].old_pdst, out_q[0].old_pdst};
  assign {io_out_prs1_3, io_out_prs1_2, io_out_prs1_1, io_out_prs1_0} = {out_q[3].prs1, out_q[2].prs1, out_q[1].prs1, out_q[0].prs1};
  assign {io_out_prs2_3, io_out_prs2_2, io_out_prs2_1, io_out_prs2_0} = {out_q[3].prs2, out_q[2].prs2, out_q[1].prs2, out_q[0].prs2};
endmodule

// File: tb/tb_rename_map.sv
// tb_rename_map: table vectors, directed corner sequences and random traffic against a rename model
module tb_rename_map;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] iv, iw, freq, cv, ov, ow;
  logic [4:0] ird [4], irs1 [4], irs2 [4], crd [4];
  logic [5:0] fpidx [4], cpd [4], opd [4], oold [4], op1 [4], op2 [4];
  logic in_ready, busy, out_ready, flush;
  int n_cmp = 0, n_bad = 0;
  int srat [32], arat [32];
  bit mv [4], mw [4];
  int mpd [4], mold [4], mp1 [4], mp2 [4];
  typedef struct packed {
    logic [3:0] v, w, req;
    logic [3:0][4:0] rd, rs1, rs2;
    logic [3:0][5:0] pidx, e1, e2, epd, eold;
  } vec_t;
  vec_t vt [4];
  always #5 clk = ~clk;
  rename_map dut (
    .clock(clk), .reset(rst),
    .io_in_valid_0(iv[0]), .io_in_valid_1(iv[1]), .io_in_valid_2(iv[2]), .io_in_valid_3(iv[3]),
    .io_in_wen_0(iw[0]), .io_in_wen_1(iw[1]), .io_in_wen_2(iw[2]), .io_in_wen_3(iw[3]),
    .io_in_rd_0(ird[0]), .io_in_rd_1(ird[1]), .io_in_rd_2(ird[2]), .io_in_rd_3(ird[3]),
    .io_in_rs1_0(irs1[0]), .io_in_rs1_1(irs1[1]), .io_in_rs1_2(irs1[2]), .io_in_rs1_3(irs1[3]),
    .io_in_rs2_0(irs2[0]), .io_in_rs2_1(irs2[1]), .io_in_rs2_2(irs2[2]), .io_in_rs2_3(irs2[3]),
    .io_in_ready(in_ready),
    .io_fl_req_0(freq[0]), .io_fl_req_1(freq[1]), .io_fl_req_2(freq[2]), .io_fl_req_3(freq[3]),
    .io_fl_pidx_0(fpidx[0]), .io_fl_pidx_1(fpidx[1]), .io_fl_pidx_2(fpidx[2]), .io_fl_pidx_3(fpidx[3]),
    .io_fl_pvld_0(freq[0]), .io_fl_pvld_1(freq[1]), .io_fl_pvld_2(freq[2]), .io_fl_pvld_3(freq[3]),
    .io_fl_busy(busy),
    .io_out_valid_0(ov[0]), .io_out_valid_1(ov[1]), .io_out_valid_2(ov[2]), .io_out_valid_3(ov[3]),
    .io_out_ready(out_ready),
    .io_out_wen_0(ow[0]), .io_out_wen_1(ow[1]), .io_out_wen_2(ow[2]), .io_out_wen_3(ow[3]),
    .io_out_pdst_0(opd[0]), .io_out_pdst_1(opd[1]), .io_out_pdst_2(opd[2]), .io_out_pdst_3(opd[3]),
    .io_out_old_pdst_0(oold[0]), .io_out_old_pdst_1(oold[1]), .io_out_old_pdst_2(oold[2]), .io_out_old_pdst_3(oold[3]),
    .io_out_prs1_0(op1[0]), .io_out_prs1_1(op1[1]), .io_out_prs1_2(op1[2]), .io_out_prs1_3(op1[3]),
    .io_out_prs2_0(op2[0]), .io_out_prs2_1(op2[1]), .io_out_prs2_2(op2[2]), .io_out_prs2_3(op2[3]),
    .io_cmt_valid_0(cv[0]), .io_cmt_valid_1(cv[1]), .io_cmt_valid_2(cv[2]), .io_cmt_valid_3(cv[3]),
    .io_cmt_rd_0(crd[0]), .io_cmt_rd_1(crd[1]), .io_cmt_rd_2(crd[2]), .io_cmt_rd_3(crd[3]),
    .io_cmt_pdst_0(cpd[0]), .io_cmt_pdst_1(cpd[1]), .io_cmt_pdst_2(cpd[2]), .io_cmt_pdst_3(cpd[3]),
    .io_flush(flush)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic clr();
    iv = '0; iw = '0; cv = '0; busy = 1'b0; flush = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      ird[k] = '0; irs1[k] = '0; irs2[k] = '0; fpidx[k] = '0; crd[k] = '0; cpd[k] = '0;
    end
  endtask
  task automatic put(input int k, input bit w, input int rd, input int rs1, input int rs2, input int pid);
    iv[k] = 1'b1; iw[k] = w; ird[k] = 5'(rd); irs1[k] = 5'(rs1); irs2[k] = 5'(rs2); fpidx[k] = 6'(pid);
  endtask
  task automatic step();
    bit rdy, w;
    int an [32], t [32];
    #1;
    rdy = !busy && !flush && (!(mv[0] || mv[1] || mv[2] || mv[3]) || out_ready);
    if (!rst) begin
      chk("in_ready", 32'(in_ready), 32'(rdy));
      for (int k = 0; k < 4; k++) chk($sformatf("fl_req_%0d", k), 32'(freq[k]), 32'(rdy && iv[k] && iw[k] && ird[k] != 0));
    end
    if (rst) begin
      for (int i = 0; i < 32; i++) begin srat[i] = i; arat[i] = i; end
      for (int k = 0; k < 4; k++) begin mv[k] = 0; mw[k] = 0; mpd[k] = 0; mold[k] = 0; mp1[k] = 0; mp2[k] = 0; end
    end else begin
      an = arat;
      for (int k = 0; k < 4; k++) if (cv[k] && crd[k] != 0) an[crd[k]] = int'(cpd[k]);
      if (flush) begin
        srat = an;
        for (int k = 0; k < 4; k++) mv[k] = 0;
      end else if (rdy) begin
        t = srat;
        for (int k = 0; k < 4; k++) begin
          w = iv[k] && iw[k] && ird[k] != 0;
          mv[k] = iv[k]; mw[k] = w;
          mp1[k] = t[irs1[k]]; mp2[k] = t[irs2[k]]; mold[k] = t[ird[k]];
          mpd[k] = w ? int'(fpidx[k]) : 0;
          if (w) t[ird[k]] = int'(fpidx[k]);
        end
        srat = t;
      end else if (out_ready) for (int k = 0; k < 4; k++) mv[k] = 0;
      arat = an;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("out_valid_%0d", k), 32'(ov[k]), 32'(mv[k]));
      if (mv[k] || rst) begin
        chk($sformatf("out_wen_%0d", k), 32'(ow[k]), 32'(mw[k]));
        chk($sformatf("pdst_%0d", k), 32'(opd[k]), mpd[k]);
        chk($sformatf("old_pdst_%0d", k), 32'(oold[k]), mold[k]);
        chk($sformatf("prs1_%0d", k), 32'(op1[k]), mp1[k]);
        chk($sformatf("prs2_%0d", k), 32'(op2[k]), mp2[k]);
      end
    end
    @(negedge clk);
  endtask
  task automatic do_reset();
    clr();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask
  initial begin
    vt[0] = '{v: 4'b0001, w: 4'b0001, req: 4'b0001,
              rd: {5'd0, 5'd0, 5'd0, 5'd5}, rs1: {5'd0, 5'd0, 5'd0, 5'd5}, rs2: {5'd0, 5'd0, 5'd0, 5'd0},
              pidx: {6'd0, 6'd0, 6'd0, 6'd32}, e1: {6'd0, 6'd0, 6'd0, 6'd5}, e2: {6'd0, 6'd0, 6'd0, 6'd0},
              epd: {6'd0, 6'd0, 6'd0, 6'd32}, eold: {6'd0, 6'd0, 6'd0, 6'd5}};
    vt[1] = '{v: 4'b0111, w: 4'b0011, req: 4'b0011,
              rd: {5'd0, 5'd7, 5'd3, 5'd3}, rs1: {5'd0, 5'd6, 5'd3, 5'd1}, rs2: {5'd0, 5'd3, 5'd4, 5'd2},
              pidx: {6'd0, 6'd0, 6'd41, 6'd40}, e1: {6'd0, 6'd6, 6'd40, 6'd1}, e2: {6'd0, 6'd41, 6'd4, 6'd2},
              epd: {6'd0, 6'd0, 6'd41, 6'd40}, eold: {6'd0, 6'd7, 6'd40, 6'd3}};
    vt[2] = '{v: 4'b0111, w: 4'b0011, req: 4'b0010,
              rd: {5'd0, 5'd0, 5'd4, 5'd0}, rs1: {5'd0, 5'd0, 5'd0, 5'd0}, rs2: {5'd0, 5'd4, 5'd0, 5'd0},
              pidx: {6'd0, 6'd0, 6'd44, 6'd60}, e1: {6'd0, 6'd0, 6'd0, 6'd0}, e2: {6'd0, 6'd44, 6'd0, 6'd0},
              epd: {6'd0, 6'd0, 6'd44, 6'd0}, eold: {6'd0, 6'd0, 6'd4, 6'd0}};
    vt[3] = '{v: 4'b1111, w: 4'b1111, req: 4'b1111,
              rd: {5'd10, 5'd10, 5'd10, 5'd10}, rs1: {5'd10, 5'd10, 5'd10, 5'd10}, rs2: {5'd3, 5'd2, 5'd1, 5'd0},
              pidx: {6'd53, 6'd52, 6'd51, 6'd50}, e1: {6'd52, 6'd51, 6'd50, 6'd10}, e2: {6'd3, 6'd2, 6'd1, 6'd0},
              epd: {6'd53, 6'd52, 6'd51, 6'd50}, eold: {6'd52, 6'd51, 6'd50, 6'd10}};
    clr();
    @(negedge clk);
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int k = 0; k < 4; k++) begin
        iv[k] = vt[v].v[k]; iw[k] = vt[v].w[k]; ird[k] = vt[v].rd[k];
        irs1[k] = vt[v].rs1[k]; irs2[k] = vt[v].rs2[k]; fpidx[k] = vt[v].pidx[k];
      end
      #1;
      chk($sformatf("vec%0d_req", v), 32'(freq), 32'(vt[v].req));
      step();
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("vec%0d_valid_%0d", v, k), 32'(ov[k]), 32'(vt[v].v[k]));
        if (vt[v].v[k]) begin
          chk($sformatf("vec%0d_prs1_%0d", v, k), 32'(op1[k]), 32'(vt[v].e1[k]));
          chk($sformatf("vec%0d_prs2_%0d", v, k), 32'(op2[k]), 32'(vt[v].e2[k]));
          chk($sformatf("vec%0d_pdst_%0d", v, k), 32'(opd[k]), 32'(vt[v].epd[k]));
          chk($sformatf("vec%0d_old_%0d", v, k), 32'(oold[k]), 32'(vt[v].eold[k]));
        end
      end
    end
    clr(); put(0, 0, 0, 10, 0, 0); step();
    chk("rat_youngest_x10", 32'(op1[0]), 32'd53);
    do_reset();
    put(0, 1, 5, 5, 0, 32); step();
    clr(); put(0, 0, 0, 5, 0, 0); step();
    chk("read_x5", 32'(op1[0]), 32'd32);
    chk("nowrite_pdst", 32'(opd[0]), 32'd0);
    clr(); out_ready = 1'b0; put(0, 1, 6, 0, 0, 33);
    #1;
    chk("bp_ready", 32'(in_ready), 32'd0);
    chk("bp_req", 32'(freq), 32'd0);
    step(); step();
    chk("bp_hold_valid", 32'(ov[0]), 32'd1);
    chk("bp_hold_prs1", 32'(op1[0]), 32'd32);
    clr(); busy = 1'b1; put(0, 1, 6, 0, 0, 33);
    #1;
    chk("busy_ready", 32'(in_ready), 32'd0);
    step();
    clr(); put(0, 0, 0, 6, 0, 0); step();
    chk("bp_no_rename_x6", 32'(op1[0]), 32'd6);
    do_reset();
    put(0, 1, 7, 0, 0, 45); cv[0] = 1'b1; crd[0] = 5'd7; cpd[0] = 6'd33; step();
    clr(); flush = 1'b1; put(0, 1, 8, 0, 0, 46);
    #1;
    chk("flush_req", 32'(freq), 32'd0);
    step();
    chk("flush_valid", 32'(ov), 32'd0);
    clr(); put(0, 0, 0, 7, 0, 0); step();
    chk("flush_x7", 32'(op1[0]), 32'd33);
    clr(); cv = 4'b1010; crd[1] = 5'd9; crd[3] = 5'd9; cpd[1] = 6'd50; cpd[3] = 6'd51; flush = 1'b1; step();
    clr(); put(0, 0, 0, 9, 0, 0); step();
    chk("cmt_collide_x9", 32'(op1[0]), 32'd51);
    clr(); put(0, 1, 9, 0, 0, 60); flush = 1'b1; cv[0] = 1'b1; crd[0] = 5'd9; cpd[0] = 6'd61;
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_valid", 32'(ov), 32'd0);
    clr(); put(0, 0, 0, 9, 0, 0); put(1, 0, 0, 7, 0, 0); step();
    chk("rst_x9", 32'(op1[0]), 32'd9);
    chk("rst_x7", 32'(op1[1]), 32'd7);
    for (int c = 0; c < 3000; c++) begin
      clr();
      for (int k = 0; k < 4; k++) begin
        iv[k] = 1'($urandom_range(1)); iw[k] = 1'($urandom_range(1));
        ird[k] = 5'($urandom_range(7)); irs1[k] = 5'($urandom_range(7)); irs2[k] = 5'($urandom_range(7));
        fpidx[k] = 6'($urandom_range(63, 32));
        cv[k] = ($urandom_range(3) == 0); crd[k] = 5'($urandom_range(7)); cpd[k] = 6'($urandom_range(63));
      end
      busy = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/rename_map.md
Name: rename_map

Overview:
- 4-wide register-rename stage of the rv64 out-of-order core. Sits directly upstream of freelist and consumes its allocated physical indices.
- Maps architectural rs1/rs2/rd through a speculative RAT, with intra-group bypass. Outputs renamed uops through a one-entry pipeline register.
- Keeps a committed (architectural) RAT, used to restore state on flush.

Parameters:
- WIDTH, 4, rename lanes per cycle; must match freelist port count
- AREG_W, 5, architectural register index width (32 regs)
- PREG_W, 6, physical register index width (64 regs)

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- io_in_valid_0..3  in  1  decoded uop valid, lane k
- io_in_wen_0..3  in  1  uop writes rd
- io_in_rd_0..3  in  5  destination arch reg
- io_in_rs1_0..3  in  5  source 1 arch reg
- io_in_rs2_0..3  in  5  source 2 arch reg
- io_in_ready  out  1  whole group accepted this cycle
- io_fl_req_0..3  out  1  allocation request to freelist
- io_fl_pidx_0..3  in  6  allocated physical index
- io_fl_pvld_0..3  in  1  allocation valid
- io_fl_busy  in  1  freelist cannot guarantee WIDTH allocations
- io_out_valid_0..3  out  1  renamed uop valid
- io_out_ready  in  1  downstream (dispatch) accepts
- io_out_wen_0..3  out  1  registered wen
- io_out_pdst_0..3  out  6  new physical destination
- io_out_old_pdst_0..3  out  6  previous mapping of rd, released at commit
- io_out_prs1_0..3  out  6  physical source 1
- io_out_prs2_0..3  out  6  physical source 2
- io_cmt_valid_0..3  in  1  commit of a writing uop
- io_cmt_rd_0..3  in  5  committed arch rd
- io_cmt_pdst_0..3  in  6  committed physical rd
- io_flush  in  1  squash all speculative state

Behaviour:
- Clock port is clock. Reset is synchronous, active-high, named reset.
- Reset state:
  - Both RATs map arch i to preg i, for i=0..31.
  - All io_out_valid_* = 0 and all out payloads = 0.
- Effective write enable: wen_k = io_in_valid_k & io_in_wen_k & (io_in_rd_k != 0). x0 is never renamed and always reads preg 0.
- Acceptance:
  - io_in_ready = !io_fl_busy & !io_flush & (out stage empty | io_out_ready).
  - Acceptance is all-or-nothing per group.
- Freelist requests:
  - io_fl_req_k = wen_k & io_in_ready.
  - The freelist answers combinationally in the same cycle.
  - io_fl_pvld_k != io_fl_req_k is a protocol error; flag it with an assertion.
- Source mapping, lane k:
  - prs = spec RAT[rs], unless some older lane j<k in the group has wen_j and rd_j==rs.
  - If so, take the youngest such j's fl_pidx_j.
- Old pdst, lane k: same rule applied to rd_k. It is the youngest older in-group writer, otherwise spec RAT[rd_k].
- Spec RAT update on accept: for each arch reg, the youngest writing lane's pidx wins. Lanes without wen leave the RAT unchanged.
- Output register:
  - Latency is 1 cycle from accept.
  - The register holds while any out_valid is set and !io_out_ready.
  - io_out_valid_k = registered io_in_valid_k. Non-writing lanes carry pdst = 0.
- Commit:
  - Arch RAT[cmt_rd_k] <= cmt_pdst_k every cycle.
  - Multiple lanes committing the same rd: the highest k wins. cmt_rd = 0 is ignored.
- Flush, in the same cycle:
  - No accept and no freelist requests.
  - Next cycle the spec RAT equals the arch RAT including this cycle's commits, and all out_valid = 0.
  - Flush has priority over the out-register hold.
- Reset mid-operation wins over flush, commit and accept.

Decomposition:
- Shared package rename_pkg holds:
  - constants WIDTH, NUM_AREG=32, NUM_PREG=64;
  - typedefs areg_t, preg_t;
  - the renamed-uop struct (valid, wen, pdst, old_pdst, prs1, prs2).
- Sub-module rename_bypass: purely combinational older-lane match and priority select for one lookup. Instantiate it three times per lane (rs1, rs2, rd).

Test Plan:
- Reset, then a group with lane0 rd=5, rs1=5 and fl_pidx_0=32 → out next cycle: prs1_0=5, pdst_0=32, old_pdst_0=5. A following uop reading x5 gets 32.
- Intra-group chain: lane0 rd=3 (pidx 40), lane1 rs1=3 rd=3 (pidx 41), lane2 rs2=3 → prs1_1=40, old_pdst_1=40, prs2_2=41. Spec RAT[3]=41 afterwards.
- x0 handling: rd=0 with wen=1 → fl_req=0, pdst=0. A source reading x0 always yields prs=0.
- Backpressure:
  - io_out_ready=0 with out valid → io_in_ready=0, no fl_req, outputs stable.
  - io_fl_busy=1 → io_in_ready=0.
- Flush: rename x7→45 and commit x7→33, then assert io_flush → next cycle all out_valid=0. A new uop reading x7 gets 33.
- Commit collision: cmt lanes 1 and 3 both rd=9 (pdst 50, 51) with a flush in the same cycle → a subsequent read of x9 yields 51.
